// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART MMIO controller: register map, STATUS/CTRL
// bit positions and the TX sequencing state encoding.
package uart_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_BAUD   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_HOLD_FULL   = 1;
    localparam int ST_TX_ACTIVE   = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_RX_FERR     = 4;
    localparam int ST_TX_DROP     = 5;

    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_RX_IRQ_EN = 2;
    localparam int CTRL_TX_IRQ_EN = 3;
    localparam int CTRL_W         = 4;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_LAUNCH    = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO for received UART data. A pop in the same cycle as a push
// on a full FIFO frees the slot so the push is accepted.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        pop_ok;
    logic        push_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: register file, TX holding register and launch
// sequencer, RX FIFO, deferred baud divisor commit and level interrupt.
module uart_mmio_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [15:0] baud_div,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_ferr
);

    tx_state_e         state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [15:0]       baud_pend_q, baud_pend_d;
    logic [15:0]       baud_div_q, baud_div_d;
    logic              overrun_q, overrun_d;
    logic              ferr_q, ferr_d;
    logic              tx_drop_q, tx_drop_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic              rx_push;
    logic              rx_pop;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       status_word;
    logic              unused_wdata;

    assign unused_wdata = ^wdata[31:16];

    assign rx_push = rx_valid && ctrl_q[CTRL_RX_EN];
    assign rx_pop  = re && (addr == ADDR_DATA);

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rx_push),
        .push_data_i (rx_data),
        .pop_i       (rx_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        status_word                 = '0;
        status_word[ST_RX_NONEMPTY] = !fifo_empty;
        status_word[ST_HOLD_FULL]   = hold_full_q;
        status_word[ST_TX_ACTIVE]   = (state_q != TX_IDLE);
        status_word[ST_RX_OVERRUN]  = overrun_q;
        status_word[ST_RX_FERR]     = ferr_q;
        status_word[ST_TX_DROP]     = tx_drop_q;
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_data_d   = tx_data_q;
        ctrl_d      = ctrl_q;
        baud_pend_d = baud_pend_q;
        baud_div_d  = baud_div_q;
        overrun_d   = overrun_q;
        ferr_d      = ferr_q;
        tx_drop_d   = tx_drop_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            TX_IDLE: begin
                if (hold_full_q && ctrl_q[CTRL_TX_EN]) begin
                    state_d   = TX_LAUNCH;
                    tx_data_d = hold_q;
                end
            end
            TX_LAUNCH: begin
                hold_full_d = 1'b0;
                state_d     = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: if (tx_busy)  state_d = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) state_d = TX_IDLE;
            default:      state_d = TX_IDLE;
        endcase

        // Clear-on-write first so a coincident hardware set overrides it.
        if (we) begin
            unique case (addr)
                ADDR_DATA: begin
                    if (!hold_full_q) begin
                        hold_d      = wdata[7:0];
                        hold_full_d = 1'b1;
                    end else begin
                        tx_drop_d = 1'b1;
                    end
                end
                ADDR_STATUS: begin
                    if (wdata[ST_RX_OVERRUN]) overrun_d = 1'b0;
                    if (wdata[ST_RX_FERR])    ferr_d    = 1'b0;
                    if (wdata[ST_TX_DROP] && !(!hold_full_q && 1'b0)) tx_drop_d = tx_drop_d & 1'b0;
                end
                ADDR_BAUD: baud_pend_d = wdata[15:0];
                default:   ctrl_d      = wdata[CTRL_W-1:0];
            endcase
        end
        if (we && addr == ADDR_DATA && hold_full_q) tx_drop_d = 1'b1;

        if (rx_push && fifo_full && !rx_pop) overrun_d = 1'b1;
        if (rx_push && rx_ferr)              ferr_d    = 1'b1;

        if (state_q == TX_IDLE && !hold_full_q) baud_div_d = baud_pend_q;

        if (re) begin
            unique case (addr)
                ADDR_DATA:   rdata_d = fifo_empty ? 32'd0 : {24'd0, fifo_head};
                ADDR_STATUS: rdata_d = status_word;
                ADDR_BAUD:   rdata_d = {16'd0, baud_pend_q};
                default:     rdata_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
            endcase
        end

        irq_d = (ctrl_q[CTRL_RX_IRQ_EN] && !fifo_empty) ||
                (ctrl_q[CTRL_TX_IRQ_EN] && !hold_full_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= TX_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_data_q   <= '0;
            ctrl_q      <= '0;
            baud_pend_q <= DEFAULT_DIV;
            baud_div_q  <= DEFAULT_DIV;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
            tx_drop_q   <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_data_q   <= tx_data_d;
            ctrl_q      <= ctrl_d;
            baud_pend_q <= baud_pend_d;
            baud_div_q  <= baud_div_d;
            overrun_q   <= overrun_d;
            ferr_q      <= ferr_d;
            tx_drop_q   <= tx_drop_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign rdata    = rdata_q;
    assign irq      = irq_q;
    assign baud_div = baud_div_q;
    assign tx_start = (state_q == TX_LAUNCH);
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed self-checking bench for uart_mmio_ctrl: register access, TX launch
// timing, RX FIFO boundaries, sticky bits, baud commit and interrupt.
module tb_uart_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [15:0] baud_div;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ferr;

    int checks = 0;
    int failures = 0;
    int start_count = 0;
    logic [31:0] rd;

    uart_mmio_ctrl #(
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .we       (we),
        .re       (re),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq),
        .baud_div (baud_div),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_start === 1'b1) start_count <= start_count + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        tick();
        re = 1'b0;
        d = rdata;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic fe);
        rx_valid = 1'b1; rx_data = b; rx_ferr = fe;
        tick();
        rx_valid = 1'b0; rx_ferr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h expected=%h", rdata, 32'd0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b expected=0", irq); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b expected=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h expected=00", tx_data); end
        checks++; if (baud_div !== 16'd434) begin failures++; $display("FAIL reset_baud_div got=%0d expected=434", baud_div); end
        rst = 1'b1;
        tick();
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'd434) begin failures++; $display("FAIL reset_read_baud got=%0d expected=434", rd); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_read_status got=%h expected=0", rd); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_read_ctrl got=%h expected=0", rd); end
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL idle_irq got=%b expected=0", irq); end
        checks++; if (start_count !== 0) begin failures++; $display("FAIL idle_no_start got=%0d expected=0", start_count); end
        $display("test_reset done");
    endtask

    task automatic test_tx_launch();
        bus_write(2'd3, 32'h1);
        bus_write(2'd0, 32'h55);
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL launch_n1_start got=%b expected=0", tx_start); end
        tick();
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL launch_n2_start got=%b expected=1", tx_start); end
        checks++; if (tx_data !== 8'h55) begin failures++; $display("FAIL launch_tx_data got=%h expected=55", tx_data); end
        tick();
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL launch_single_pulse got=%b expected=0", tx_start); end
        tx_busy = 1'b1;
        repeat (9) tick();
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h04) begin failures++; $display("FAIL launch_busy_status got=%h expected=04", rd); end
        tx_busy = 1'b0;
        tick();
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL launch_idle_status got=%h expected=00", rd); end
        checks++; if (tx_data !== 8'h55) begin failures++; $display("FAIL launch_data_stable got=%h expected=55", tx_data); end
        $display("test_tx_launch done");
    endtask

    task automatic test_back_to_back();
        bus_write(2'd0, 32'hA5);
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin failures++; $display("FAIL b2b_first start=%b data=%h expected=1/a5", tx_start, tx_data); end
        tx_busy = 1'b1;
        tick();
        bus_write(2'd0, 32'h3C);
        bus_write(2'd0, 32'h99);
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h26) begin failures++; $display("FAIL b2b_drop_status got=%h expected=26", rd); end
        tick();
        tx_busy = 1'b0;
        tick();
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL b2b_early_start got=%b expected=0", tx_start); end
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin failures++; $display("FAIL b2b_second start=%b data=%h expected=1/3c", tx_start, tx_data); end
        tick();
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL b2b_drop_clear got=%h expected=00", rd); end
        checks++; if (start_count !== 3) begin failures++; $display("FAIL b2b_start_count got=%0d expected=3", start_count); end
        $display("test_back_to_back done");
    endtask

    task automatic test_tx_en_clear();
        bus_write(2'd0, 32'h01);
        tick();
        tx_busy = 1'b1;
        tick();
        bus_write(2'd0, 32'h02);
        bus_write(2'd3, 32'h0);
        tx_busy = 1'b0;
        repeat (5) tick();
        checks++; if (start_count !== 4) begin failures++; $display("FAIL txen_no_relaunch got=%0d expected=4", start_count); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h02) begin failures++; $display("FAIL txen_hold_kept got=%h expected=02", rd); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL txen_reset_clear got=%h expected=00", rd); end
        $display("test_tx_en_clear done");
    endtask

    task automatic test_rx_fifo();
        bus_write(2'd3, 32'h2);
        for (int i = 1; i <= 5; i++) rx_send(8'(i), 1'b0);
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h09) begin failures++; $display("FAIL rx_overrun_status got=%h expected=09", rd); end
        for (int i = 1; i <= 4; i++) begin
            bus_read(2'd0, rd);
            checks++; if (rd !== 32'(i)) begin failures++; $display("FAIL rx_read_%0d got=%h expected=%h", i, rd, 32'(i)); end
        end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rx_read_empty got=%h expected=0", rd); end
        bus_write(2'd1, 32'h08);
        bus_write(2'd3, 32'h0);
        rx_send(8'hEE, 1'b0);
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL rx_disabled_ignored got=%h expected=00", rd); end
        $display("test_rx_fifo done");
    endtask

    task automatic test_rx_simul();
        bus_write(2'd3, 32'h2);
        for (int i = 0; i < 4; i++) rx_send(8'(8'h10 + i), 1'b0);
        rx_valid = 1'b1; rx_data = 8'h77; addr = 2'd0; re = 1'b1;
        tick();
        rx_valid = 1'b0; re = 1'b0;
        checks++; if (rdata !== 32'h10) begin failures++; $display("FAIL simul_full_read got=%h expected=10", rdata); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h01) begin failures++; $display("FAIL simul_no_overrun got=%h expected=01", rd); end
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd0, rd);
            checks++; if (rd !== ((i == 3) ? 32'h77 : 32'(8'h11 + i))) begin failures++; $display("FAIL simul_drain_%0d got=%h", i, rd); end
        end
        rx_valid = 1'b1; rx_data = 8'h42; addr = 2'd0; re = 1'b1;
        tick();
        rx_valid = 1'b0; re = 1'b0;
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL simul_empty_read got=%h expected=0", rdata); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'h42) begin failures++; $display("FAIL simul_byte_kept got=%h expected=42", rd); end
        rx_send(8'h5A, 1'b1);
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h11) begin failures++; $display("FAIL ferr_set got=%h expected=11", rd); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'h5A) begin failures++; $display("FAIL ferr_byte_pushed got=%h expected=5a", rd); end
        rx_valid = 1'b1; rx_data = 8'h66; rx_ferr = 1'b1;
        addr = 2'd1; wdata = 32'h10; we = 1'b1;
        tick();
        rx_valid = 1'b0; rx_ferr = 1'b0; we = 1'b0;
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h11) begin failures++; $display("FAIL ferr_set_wins got=%h expected=11", rd); end
        bus_read(2'd0, rd);
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL ferr_clear got=%h expected=00", rd); end
        $display("test_rx_simul done");
    endtask

    task automatic test_baud_irq();
        bus_write(2'd3, 32'h1);
        bus_write(2'd0, 32'h11);
        tick();
        tx_busy = 1'b1;
        tick();
        bus_write(2'd2, 32'd27);
        repeat (3) tick();
        checks++; if (baud_div !== 16'd434) begin failures++; $display("FAIL baud_held got=%0d expected=434", baud_div); end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'd27) begin failures++; $display("FAIL baud_pending got=%0d expected=27", rd); end
        tx_busy = 1'b0;
        tick();
        checks++; if (baud_div !== 16'd434) begin failures++; $display("FAIL baud_not_yet got=%0d expected=434", baud_div); end
        tick();
        checks++; if (baud_div !== 16'd27) begin failures++; $display("FAIL baud_commit got=%0d expected=27", baud_div); end
        bus_write(2'd3, 32'h6);
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_empty got=%b expected=0", irq); end
        rx_send(8'hAB, 1'b0);
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx got=%b expected=1", irq); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'hAB) begin failures++; $display("FAIL irq_byte got=%h expected=ab", rd); end
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_cleared got=%b expected=0", irq); end
        bus_write(2'd3, 32'h8);
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx_empty got=%b expected=1", irq); end
        bus_write(2'd3, 32'h0);
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%b expected=0", irq); end
        $display("test_baud_irq done");
    endtask

    task automatic test_reset_mid_frame();
        bus_write(2'd3, 32'h1);
        bus_write(2'd0, 32'h7E);
        tick();
        tx_busy = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL midrst_outputs start=%b data=%h expected=0/00", tx_start, tx_data); end
        checks++; if (baud_div !== 16'd434) begin failures++; $display("FAIL midrst_baud got=%0d expected=434", baud_div); end
        tick();
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL midrst_status got=%h expected=00", rd); end
        tx_busy = 1'b0;
        repeat (3) tick();
        checks++; if (start_count !== 6) begin failures++; $display("FAIL midrst_no_reissue got=%0d expected=6", start_count); end
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        rst = 1'b0; addr = 2'd0; we = 1'b0; re = 1'b0; wdata = '0;
        tx_busy = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_ferr = 1'b0;
        test_reset();
        test_tx_launch();
        test_back_to_back();
        test_tx_en_clear();
        test_rx_fifo();
        test_rx_simul();
        test_baud_irq();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped controller that sequences the UART transmitter and receiver cores for the MIPS system. It sits between the MIPS data-bus decode and the `baud_gen`/UART TX/RX datapath. It holds one TX byte and launches it into the TX core, and buffers received bytes in a small FIFO. It also owns the baud divisor and control configuration, and raises an interrupt request.

## Interface
- `FIFO_DEPTH`, 4: RX FIFO entries; power of two, ≥2.
- `DEFAULT_DIV`, 16'd434: baud divisor after reset (50 MHz / 115200).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge).
- `addr`  in  2  word select: 0 DATA, 1 STATUS, 2 BAUD, 3 CTRL.
- `we`  in  1  write strobe, one cycle per access.
- `re`  in  1  read strobe, one cycle per access.
- `wdata`  in  32  write data.
- `rdata`  out  32  registered read data.
- `irq`  out  1  interrupt request, level.
- `baud_div`  out  16  divisor to `baud_gen`.
- `tx_start`  out  1  one-cycle launch pulse to TX core.
- `tx_data`  out  8  byte to TX core, stable while `tx_busy`.
- `tx_busy`  in  1  TX core is shifting a frame.
- `rx_valid`  in  1  one-cycle pulse: byte received.
- `rx_data`  in  8  received byte, valid with `rx_valid`.
- `rx_ferr`  in  1  stop-bit error, valid with `rx_valid`.

## Operation
- **Reset values:** `rdata`=0, `irq`=0, `tx_start`=0, `tx_data`=0, `baud_div`=`DEFAULT_DIV`. CTRL=0. All sticky bits=0. FIFO empty, holding register empty, TX FSM in IDLE.
- **DATA write:** the byte `wdata[7:0]` goes to the TX holding register if it is empty. If the holding register is full, the write is dropped and `tx_drop` is set.
- **DATA read:** returns the FIFO head in `rdata[7:0]` and pops it. If the FIFO is empty, it returns 0 with no pop.
- **STATUS read:** bit0 `rx_nonempty`, bit1 `hold_full`, bit2 `tx_active` (FSM ≠ IDLE), bit3 `rx_overrun`, bit4 `rx_ferr_sticky`, bit5 `tx_drop`. Other bits are 0.
- **STATUS write:** writing 1 to bits 3..5 clears those bits. Writing 0 has no effect.
- **CTRL:** bit0 `tx_en`, bit1 `rx_en`, bit2 `rx_irq_en`, bit3 `tx_irq_en`. CTRL is read/write.
- **BAUD:** writes update a pending divisor (`wdata[15:0]`). `baud_div` takes the pending value only when the TX FSM is IDLE and the holding register is empty. BAUD reads return the pending value.
- **RX path:** on `rx_valid` with `rx_en`=1, push `rx_data` into the FIFO.
  - If the FIFO is full, drop the byte and set `rx_overrun`.
  - If `rx_ferr`=1, set `rx_ferr_sticky`; the byte is still pushed.
  - When `rx_en`=0, `rx_valid` is ignored.
- **TX FSM transitions:**
  - IDLE→LAUNCH when `hold_full` & `tx_en`.
  - LAUNCH: assert `tx_start`, drive `tx_data` from holding, clear `hold_full`; → WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE on `tx_busy`=1.
  - WAIT_DONE → IDLE on `tx_busy`=0.
- **IRQ:** `irq` = (`rx_irq_en` & `rx_nonempty`) | (`tx_irq_en` & !`hold_full`), registered.

## Timing
- A DATA write in cycle n sets `hold_full` at n+1. With the FSM IDLE and `tx_en`=1, `tx_start` is high in cycle n+2 and `hold_full` reads 0 from n+3.
- A second byte may be written during WAIT_BUSY/WAIT_DONE. It launches 2 cycles after the falling edge of `tx_busy` is sampled.
- Reads: `rdata` is valid in the cycle after `re`. The pop is visible in `rx_nonempty` in that same cycle.
- **Simultaneous push and pop on a full FIFO:** the pop frees an entry, the push succeeds, and no overrun occurs. Push on an empty FIFO with a read in the same cycle: the read returns 0, and the byte remains.
- **Simultaneous sticky set and clear-write:** set wins.
- **`tx_en` cleared mid-frame:** the current frame completes; no new launch occurs.
- **Reset asserted mid-frame:** the FSM returns to IDLE immediately. `tx_start` is not reissued, and the TX core's in-flight frame is not tracked.
- `we` and `re` in the same cycle: both take effect; `rdata` returns pre-write state.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap modulo 2·`FIFO_DEPTH`. Full = MSBs differ and LSBs equal.

## Structure
- Package `uart_ctrl_pkg` holds:
  - register offsets (DATA/STATUS/BAUD/CTRL);
  - STATUS and CTRL bit indices;
  - TX FSM state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
- Sub-module `uart_rx_fifo` (parameter `FIFO_DEPTH`, 8-bit): push/pop/full/empty/head, with simultaneous push+pop support.
- Top level holds the register file, TX FSM, baud commit logic, and irq.

## Test plan
- **Reset then idle reads:** read BAUD → 434, read STATUS → 0, read CTRL → 0; `irq`=0, `tx_start` never pulses.
- **TX launch:** CTRL=1, write DATA 0x55 in cycle n → `tx_start` in n+2 with `tx_data`=0x55. Model `tx_busy` high for 10 cycles → FSM returns to IDLE.
- **Back-to-back TX:** write 0xA5 and 0x3C during busy, then a third write → `tx_drop`=1. 0x3C launches 2 cycles after `tx_busy` falls. Write 0x20 to STATUS → `tx_drop`=0.
- **RX FIFO:** CTRL=2, send 5 `rx_valid` bytes 0x01..0x05 → `rx_overrun`=1. Reads return 0x01..0x04, then 0.
- **RX simultaneous push and pop:** fill the FIFO, then `rx_valid`=0x77 in the same cycle as a DATA read → no overrun, and 0x77 is read last. `rx_ferr`=1 → bit4 set.
- **Baud commit and IRQ:** write BAUD=27 while TX is busy → `baud_div` stays 434 until IDLE, then becomes 27. CTRL=0x6 with one RX byte → `irq`=1, cleared after the byte is read.
